// File: rtl/shared_mem_arbiter.sv
// Single-ported shared word memory for the MIPS core, arbitrating instruction fetch and data load/store.
// Define SHARED_MEM_ROUND_ROBIN_EN for round-robin arbitration; by default the data port has fixed priority.
module shared_mem_arbiter #(
   parameter int ADDR_BITS   = 6,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        busy
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                 state;
   logic [3:0]             counter;
   logic                   sel_data;
   logic                   op_we;
   logic [ADDR_BITS-1:0]   op_index;
   logic [31:0]            op_wdata;
   logic                   last_grant;
   logic                   grant_data;
   logic [31:0]            mem [DEPTH];

   logic [ADDR_BITS-1:0]   if_index;
   logic [ADDR_BITS-1:0]   d_index;
   logic                   unused_bits;

   assign if_index    = if_addr[ADDR_BITS+1:2];
   assign d_index     = d_addr[ADDR_BITS+1:2];
   assign busy        = (state != IDLE);
   assign unused_bits = ^{if_addr[31:ADDR_BITS+2], if_addr[1:0],
                          d_addr[31:ADDR_BITS+2], d_addr[1:0], last_grant};

   // Winner selection; last_grant is 1 when the data port won the previous grant.
   always_comb begin
      grant_data = d_req;
`ifdef SHARED_MEM_ROUND_ROBIN_EN
      if (d_req && if_req) begin
         grant_data = ~last_grant;
      end
`endif
   end

   // The valid pulse is registered on the RESP->IDLE edge, so it appears
   // WAIT_STATES+2 edges after the grant and never overlaps the next access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         counter    <= 4'd0;
         sel_data   <= 1'b0;
         op_we      <= 1'b0;
         op_index   <= '0;
         op_wdata   <= 32'd0;
         last_grant <= 1'b0;
         if_valid   <= 1'b0;
         d_valid    <= 1'b0;
         if_rdata   <= 32'd0;
         d_rdata    <= 32'd0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req || d_req) begin
                  sel_data   <= grant_data;
                  last_grant <= grant_data;
                  op_index   <= grant_data ? d_index : if_index;
                  op_we      <= grant_data & d_we;
                  op_wdata   <= d_wdata;
                  counter    <= 4'(WAIT_STATES);
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (counter != 4'd0) begin
                  counter <= counter - 4'd1;
               end else begin
                  if (!op_we) begin
                     if (sel_data) begin
                        d_rdata <= mem[op_index];
                     end else begin
                        if_rdata <= mem[op_index];
                     end
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               if (sel_data) begin
                  d_valid <= 1'b1;
               end else begin
                  if_valid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array is never reset; a reset before the operation edge leaves it untouched.
   always_ff @(posedge clk) begin
      if (state == ACCESS && counter == 4'd0 && op_we) begin
         mem[op_index] <= op_wdata;
      end
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: the driver pushes expected completions,
// a negedge monitor pops and compares them whenever a valid pulse appears.
module tb_shared_mem_arbiter;

   localparam int WS = 1;
   localparam int AB = 6;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        busy;

   typedef struct {
      bit          is_data;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks;
   int          errors;
   logic [31:0] model_d_rdata;

   shared_mem_arbiter #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_valid && d_valid) checkOutput("both_valid", 32'd1, 32'd0);
         if (if_valid || d_valid) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("valid_port", {31'd0, d_valid}, {31'd0, e.is_data});
               checkOutput("rdata", d_valid ? d_rdata : if_rdata, e.data);
            end
         end
      end
   end

   task automatic waitValid(input bit is_data, output int cycles, output int busy_cycles);
      bit seen;
      seen        = 0;
      cycles      = 0;
      busy_cycles = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         cycles++;
         if (busy) busy_cycles++;
         if (is_data ? d_valid : if_valid) seen = 1;
      end
      if (!seen) checkOutput("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic pushExp(input bit is_data, input bit we, input logic [31:0] expd);
      exp_t e;
      e.is_data = is_data;
      if (is_data && !we) model_d_rdata = expd;
      e.data = (is_data && we) ? model_d_rdata : expd;
      sb.push_back(e);
   endtask

   // One access on an idle DUT; called just after a negedge.
   task automatic applyStimulus(input bit is_data, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expd);
      int cyc;
      int bcyc;
      if (is_data) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      pushExp(is_data, we, expd);
      waitValid(is_data, cyc, bcyc);
      checkOutput("latency", cyc, WS + 3);
      checkOutput("busy_cycles", bcyc, WS + 2);
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
   endtask

   initial begin
      int cyc;
      int bcyc;
      checks = 0;
      errors = 0;
      model_d_rdata = 32'd0;
      reset = 1'b0;
      if_req = 1'b0; if_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;

      repeat (2) @(negedge clk);
      checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("rst_d_valid", {31'd0, d_valid}, 32'd0);
      checkOutput("rst_if_rdata", if_rdata, 32'd0);
      checkOutput("rst_d_rdata", d_rdata, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] store/load round trip");
      applyStimulus(1, 1, 32'h0000_0014, 32'hDEAD_BEEF, 32'd0);
      applyStimulus(1, 0, 32'h0000_0014, 32'd0, 32'hDEAD_BEEF);
      applyStimulus(1, 1, 32'h0000_0000, 32'h1111_2222, 32'd0);
      applyStimulus(1, 1, 32'h0000_0008, 32'h3333_4444, 32'd0);
      applyStimulus(0, 0, 32'h0000_0000, 32'd0, 32'h1111_2222);

      $display("[TB] address aliasing");
      applyStimulus(1, 1, 32'h0000_0104, 32'hA5A5_5A5A, 32'd0);
      applyStimulus(1, 0, 32'h0000_0004, 32'd0, 32'hA5A5_5A5A);
      applyStimulus(1, 0, 32'h8000_0017, 32'd0, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 32'h0000_0000, 32'd0, 32'h1111_2222);

      $display("[TB] simultaneous requests");
      if_req = 1'b1; if_addr = 32'h0000_0000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
      pushExp(1, 0, 32'h3333_4444);
      pushExp(0, 0, 32'h1111_2222);
      waitValid(1, cyc, bcyc);
      checkOutput("sim_d_latency", cyc, WS + 3);
      d_req = 1'b0;
      waitValid(0, cyc, bcyc);
      checkOutput("sim_if_gap", cyc, WS + 3);
      if_req = 1'b0;

      $display("[TB] sustained contention");
      if_req = 1'b1; d_req = 1'b1;
`ifdef SHARED_MEM_ROUND_ROBIN_EN
      pushExp(1, 0, 32'h3333_4444);
      pushExp(0, 0, 32'h1111_2222);
      pushExp(1, 0, 32'h3333_4444);
      pushExp(0, 0, 32'h1111_2222);
`else
      repeat (4) pushExp(1, 0, 32'h3333_4444);
`endif
      for (int k = 0; k < 4; k++) begin
         bit seen;
         seen = 0;
         cyc  = 0;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (if_valid || d_valid) seen = 1;
         end
         checkOutput("contention_period", cyc, WS + 3);
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (WS + 4) @(negedge clk);
      checkOutput("sb_drained", sb.size(), 32'd0);

      $display("[TB] reset during access");
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0014; d_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      checkOutput("granted_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_if_rdata", if_rdata, 32'd0);
      checkOutput("mid_rst_d_rdata", d_rdata, 32'd0);
      checkOutput("mid_rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
      d_req = 1'b0; d_we = 1'b0;
      model_d_rdata = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (WS + 4) @(negedge clk);
      checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);
      applyStimulus(1, 0, 32'h0000_0014, 32'd0, 32'hDEAD_BEEF);

      repeat (3) @(negedge clk);
      checkOutput("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
